conv2d_layer_seq: RTL

//  Sequencer for one conv2d layer instance. Issues the weight and bias load strobes,

---
 rtl/conv2d_layer_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/conv2d_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_layer_seq
// Description : Control sequencer for one conv2d layer. It loads the weights
//               and biases, gates input columns into the conv datapath, waits
//               out the pipeline latency and hands each result frame on.
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_layer_seq #(
  parameter int NUM_SAMPLES  = 32,
  parameter int PIPE_LATENCY = 3,
  parameter int FRAME_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  reload_cfg,
  input  logic [FRAME_BITS-1:0] num_frames,
  input  logic                  abort,
  input  logic                  cfg_valid,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  conv_data_valid,
  output logic                  conv_load_weights,
  output logic                  conv_load_biases,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FRAME_BITS-1:0] frame_idx,
  output logic                  cfg_loaded,
  output logic                  busy,
  output logic                  done
);

  localparam int COL_W = $clog2(NUM_SAMPLES + 1);
  localparam int LAT_W = (PIPE_LATENCY < 2) ? 1 : $clog2(PIPE_LATENCY);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(NUM_SAMPLES - 1);
  localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(PIPE_LATENCY - 1);
  localparam logic [FRAME_BITS-1:0] ONE_F    = FRAME_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_B = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_OUTPUT = 3'd5
  } state_t;

  state_t                  state_q,      state_d;
  logic [FRAME_BITS-1:0]   frames_q,     frames_d;
  logic [FRAME_BITS-1:0]   frame_idx_q,  frame_idx_d;
  logic [COL_W-1:0]        col_cnt_q,    col_cnt_d;
  logic [LAT_W-1:0]        lat_cnt_q,    lat_cnt_d;
  logic                    cfg_loaded_q, cfg_loaded_d;
  logic                    out_valid_q,  out_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frames_q     <= '0;
      frame_idx_q  <= '0;
      col_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      cfg_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frames_q     <= frames_d;
      frame_idx_q  <= frame_idx_d;
      col_cnt_q    <= col_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      cfg_loaded_q <= cfg_loaded_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    frames_d          = frames_q;
    frame_idx_d       = frame_idx_q;
    col_cnt_d         = col_cnt_q;
    lat_cnt_d         = lat_cnt_q;
    cfg_loaded_d      = cfg_loaded_q;
    out_valid_d       = out_valid_q;
    in_ready          = 1'b0;
    conv_load_weights = 1'b0;
    conv_load_biases  = 1'b0;
    done              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          frames_d    = (num_frames == '0) ? ONE_F : num_frames;
          frame_idx_d = '0;
          col_cnt_d   = '0;
          lat_cnt_d   = '0;
          state_d     = (reload_cfg || !cfg_loaded_q) ? S_LOAD_W : S_STREAM;
        end
      end
      S_LOAD_W: begin
        if (cfg_valid) begin
          conv_load_weights = 1'b1;
          state_d           = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        if (cfg_valid) begin
          conv_load_biases = 1'b1;
          cfg_loaded_d     = 1'b1;
          state_d          = S_STREAM;
        end
      end
      S_STREAM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            lat_cnt_d = '0;
            state_d   = S_DRAIN;
          end else begin
            col_cnt_d = col_cnt_q + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d   = '0;
          out_valid_d = 1'b1;
          state_d     = S_OUTPUT;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (frame_idx_q == frames_q - ONE_F) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_idx_d = frame_idx_q + ONE_F;
            state_d     = S_STREAM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything except in_ready, so a same-cycle beat still reaches conv.
    if (abort && (state_q != S_IDLE)) begin
      state_d           = S_IDLE;
      frame_idx_d       = '0;
      col_cnt_d         = '0;
      lat_cnt_d         = '0;
      out_valid_d       = 1'b0;
      cfg_loaded_d      = cfg_loaded_q;
      conv_load_weights = 1'b0;
      conv_load_biases  = 1'b0;
      done              = 1'b0;
    end
  end

  assign conv_data_valid = in_valid & in_ready;
  assign out_valid       = out_valid_q;
  assign frame_idx       = frame_idx_q;
  assign cfg_loaded      = cfg_loaded_q;
  assign busy            = (state_q != S_IDLE);

endmodule
`default_nettype wire
